// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state encoding and iteration constants for the multdiv sequencer.
package multdiv_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    localparam int MULTDIV_DIV_ITERS   = 32;
    localparam int MULTDIV_BOOTH_ITERS = MULTDIV_DIV_ITERS / 2;
    localparam int MULTDIV_CNT_W       = 5;
endpackage

// File: rtl/count_down_32.sv
// count_down_32: loadable, enabled down-counter with a zero flag.
module count_down_32
    import multdiv_pkg::*;
#(
    parameter int W = MULTDIV_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic [W-1:0] out,
    output logic         zero
);
    always_ff @(posedge clk) begin
        if (reset) out <= '0;
        else if (load) out <= load_value;
        else if (en) out <= out - 1'b1;
    end
    assign zero = (out == '0);
endmodule

// File: rtl/multdiv_seq.sv
// multdiv_seq: iteration sequencer for the iterative multiplier/divider.
// Define MULTDIV_SEQ_BOOTH_EN for radix-4 Booth multiply (half the multiply iterations).
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int DIV_ITERS = MULTDIV_DIV_ITERS,
    parameter int CNT_W     = MULTDIV_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             div_by_zero,
    output logic             busy,
    output logic             op_is_div,
    output logic             load,
    output logic             step,
    output logic [CNT_W-1:0] iter,
    output logic             data_resultRDY,
    output logic             data_exception
);
`ifdef MULTDIV_SEQ_BOOTH_EN
    localparam int MULT_N = DIV_ITERS / 2;
`else
    localparam int MULT_N = DIV_ITERS;
`endif
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_ITERS - 1);
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_N - 1);

    state_t state, state_next;
    logic start, exc, zero, dbz, cnt_load;

    assign start = ctrl_MULT || ctrl_DIV;
    assign dbz   = op_is_div && div_by_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_is_div <= 1'b0;
            exc       <= 1'b0;
        end else begin
            state <= state_next;
            if (start) op_is_div <= ctrl_DIV && !ctrl_MULT;
            if (state == LOAD) exc <= dbz;
        end
    end

    // Any ctrl pulse restarts at LOAD, aborting whatever is in flight.
    always_comb begin
        state_next     = start ? LOAD
                       : state == LOAD ? (dbz ? DONE : RUN)
                       : state == RUN  ? (zero ? DONE : RUN)
                       : IDLE;
        busy           = (state == LOAD) || (state == RUN);
        load           = state == LOAD;
        step           = state == RUN;
        data_resultRDY = state == DONE;
        data_exception = (state == DONE) && exc;
        cnt_load       = (state == LOAD) && !dbz;
    end

    count_down_32 #(.W(CNT_W)) u_iter (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load),
        .load_value(op_is_div ? DIV_LAST : MULT_LAST),
        .en        (step && !zero),
        .out       (iter),
        .zero      (zero)
    );
endmodule

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq: directed timeline checks for multdiv_seq.
`timescale 1ns/1ps
module tb_multdiv_seq;
`ifdef MULTDIV_SEQ_BOOTH_EN
    localparam int MULT_N = 16;
`else
    localparam int MULT_N = 32;
`endif
    localparam int DIV_N = 32;

    logic clk = 1'b0, reset = 1'b0, ctrl_MULT = 1'b0, ctrl_DIV = 1'b0, div_by_zero = 1'b0;
    logic busy, op_is_div, load, step, data_resultRDY, data_exception;
    logic [4:0] iter;
    logic [5:0] outv;
    int checks = 0, errors = 0;

    assign outv = {busy, op_is_div, load, step, data_resultRDY, data_exception};

    multdiv_seq dut (
        .clk           (clk),
        .reset         (reset),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .div_by_zero   (div_by_zero),
        .busy          (busy),
        .op_is_div     (op_is_div),
        .load          (load),
        .step          (step),
        .iter          (iter),
        .data_resultRDY(data_resultRDY),
        .data_exception(data_exception)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (outv !== 6'b0 || iter !== 5'd0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: outputs=%b iter=%0d, want 000000 iter=0", c, outv, iter);
            end
        end
        reset = 1'b1;
        ctrl_MULT = 1'b1;
        tick();
        reset = 1'b0;
        ctrl_MULT = 1'b0;
        checks++;
        if (outv !== 6'b0) begin
            errors++;
            $display("FAIL reset_priority: outputs=%b, want 000000", outv);
        end
        tick();
        checks++;
        if (outv !== 6'b0) begin
            errors++;
            $display("FAIL reset_priority_after: outputs=%b, want 000000", outv);
        end
    endtask

    task automatic test_timeline(input logic div, input int n);
        logic [5:0] exp;
        logic [4:0] exp_iter;
        ctrl_DIV = div;
        ctrl_MULT = !div;
        tick();
        ctrl_DIV = 1'b0;
        ctrl_MULT = 1'b0;
        for (int c = 1; c <= n + 3; c++) begin
            exp = {c <= n + 1, div, c == 1, c >= 2 && c <= n + 1, c == n + 2, 1'b0};
            checks++;
            if (outv !== exp) begin
                errors++;
                $display("FAIL timeline div=%0d cycle %0d: outputs=%b, want %b", div, c, outv, exp);
            end
            if (c >= 2 && c <= n + 1) begin
                exp_iter = 5'(n + 1 - c);
                checks++;
                if (iter !== exp_iter) begin
                    errors++;
                    $display("FAIL iter div=%0d cycle %0d: iter=%0d, want %0d", div, c, iter, exp_iter);
                end
            end
            tick();
        end
    endtask

    task automatic test_div_zero();
        ctrl_DIV = 1'b1;
        tick();
        ctrl_DIV = 1'b0;
        div_by_zero = 1'b1;
        checks++;
        if (outv !== 6'b111000) begin
            errors++;
            $display("FAIL dbz_load: outputs=%b, want 111000", outv);
        end
        tick();
        div_by_zero = 1'b0;
        checks++;
        if (outv !== 6'b010011) begin
            errors++;
            $display("FAIL dbz_done: outputs=%b, want 010011", outv);
        end
        tick();
        checks++;
        if (outv !== 6'b010000) begin
            errors++;
            $display("FAIL dbz_idle: outputs=%b, want 010000", outv);
        end
    endtask

    task automatic test_restart();
        int rdy_count = 0;
        ctrl_MULT = 1'b1;
        tick();
        ctrl_MULT = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (data_resultRDY === 1'b1) rdy_count++;
            tick();
        end
        ctrl_DIV = 1'b1;
        tick();
        ctrl_DIV = 1'b0;
        checks++;
        if (load !== 1'b1 || op_is_div !== 1'b1) begin
            errors++;
            $display("FAIL restart_load: load=%b op_is_div=%b, want 1 1", load, op_is_div);
        end
        for (int c = 11; c <= 46; c++) begin
            if (data_resultRDY === 1'b1) rdy_count++;
            if (c == 44) begin
                checks++;
                if (data_resultRDY !== 1'b1) begin
                    errors++;
                    $display("FAIL restart_rdy cycle 44: rdy=%b, want 1", data_resultRDY);
                end
            end
            tick();
        end
        checks++;
        if (rdy_count != 1) begin
            errors++;
            $display("FAIL restart_rdy_count: got %0d, want 1", rdy_count);
        end
    endtask

    task automatic test_reset_mid();
        int rdy_count = 0;
        ctrl_DIV = 1'b1;
        tick();
        ctrl_DIV = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        checks++;
        if (step !== 1'b1) begin
            errors++;
            $display("FAIL mid_running: step=%b, want 1", step);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (outv !== 6'b0 || iter !== 5'd0) begin
            errors++;
            $display("FAIL mid_reset: outputs=%b iter=%0d, want 000000 iter=0", outv, iter);
        end
        for (int c = 0; c < 40; c++) begin
            if (data_resultRDY === 1'b1) rdy_count++;
            tick();
        end
        checks++;
        if (rdy_count != 0) begin
            errors++;
            $display("FAIL mid_reset_rdy: got %0d pulses, want 0", rdy_count);
        end
    endtask

    initial begin
        test_reset();
        test_timeline(1'b1, DIV_N);
        test_timeline(1'b0, MULT_N);
        test_div_zero();
        test_restart();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
